// File: rtl/rx_cmd_decoder.sv
// UART command decoder: edge-detects rx bytes into a small FIFO and
// executes one queued command every two cycles (flap/pause/restart/level).
module rx_cmd_decoder #(
  parameter int DEPTH   = 4,
  parameter int HOLDOFF = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  output logic       flap,
  output logic       game_rst,
  output logic       paused,
  output logic [3:0] level,
  output logic       fifo_full,
  output logic       overflow,
  output logic [7:0] drop_cnt,
  output logic [7:0] unk_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(HOLDOFF + 1);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t        state;
  logic [7:0]    rx_prev;
  logic [7:0]    cmd_reg;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [HW-1:0] hold_cnt;

  logic new_byte;
  logic full;
  logic pop;
  logic push;
  logic is_flap;
  logic is_pause;
  logic is_rst;
  logic is_lvl;

  assign new_byte  = (rx_byte != 8'd0) && (rx_byte != rx_prev);
  assign full      = (count == (AW+1)'(DEPTH));
  assign pop       = (state == IDLE) && (count != '0);
  assign push      = new_byte && (!full || pop);
  assign fifo_full = full;

  assign is_flap  = (cmd_reg == 8'h20) || (cmd_reg == 8'h46) ||
                    (cmd_reg == 8'h66);
  assign is_pause = (cmd_reg == 8'h50) || (cmd_reg == 8'h70);
  assign is_rst   = (cmd_reg == 8'h52) || (cmd_reg == 8'h72);
  assign is_lvl   = (cmd_reg >= 8'h30) && (cmd_reg <= 8'h39);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_prev  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      rx_prev <= rx_byte;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (new_byte && !push) overflow <= 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cmd_reg  <= '0;
      flap     <= 1'b0;
      game_rst <= 1'b0;
      paused   <= 1'b0;
      level    <= '0;
      hold_cnt <= '0;
      drop_cnt <= '0;
      unk_cnt  <= '0;
    end else begin
      flap     <= 1'b0;
      game_rst <= 1'b0;
      if (hold_cnt != '0) hold_cnt <= hold_cnt - HW'(1);
      unique case (state)
        IDLE: begin
          if (pop) begin
            cmd_reg <= mem[rd_ptr];
            state   <= EXEC;
          end
        end
        EXEC: begin
          state <= IDLE;
          unique case (1'b1)
            is_flap: begin
              if (!paused && hold_cnt == '0) begin
                flap     <= 1'b1;
                hold_cnt <= HW'(HOLDOFF - 1);
              end else if (drop_cnt != 8'hff) begin
                drop_cnt <= drop_cnt + 8'd1;
              end
            end
            is_pause: paused <= ~paused;
            is_rst: begin
              game_rst <= 1'b1;
              paused   <= 1'b0;
              hold_cnt <= '0;
            end
            // 0x30-0x39: low nibble is the digit value
            is_lvl: level <= cmd_reg[3:0];
            default: begin
              if (unk_cnt != 8'hff) unk_cnt <= unk_cnt + 8'd1;
            end
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
